ecc_dec_resp: RTL and testbench

Registered response stage directly downstream of the 32-bit SEC-DED decoder. It accepts the decoder's corrected 39-bit codeword and error flags with a valid/ready handshake, and delivers 32-bit read data plus a poison flag one cycle later. It also counts corrected and uncorrectable errors, logs the first error's syndrome and address, and issues single-entry scrub write-back requests so memory holds the corrected codeword.

---
 rtl/ecc_pkg.sv | 27 ++
 rtl/sat_counter.sv | 36 +++
 rtl/ecc_dec_resp.sv | 217 +++++++++++++++++++++
 tb/tb_ecc_dec_resp.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared constants, types and helpers for the SEC-DED read path.
//   DATA_W / CHK_W / CW_W : data, check-bit and codeword widths
//   scrub_state_t         : scrub write-back FSM states
//   ecc_flags_t           : decoder error flags bundled together
package ecc_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 7;
  localparam int CW_W   = 39;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } scrub_state_t;

  typedef struct packed {
    logic err;
    logic sgl;
    logic dbl;
  } ecc_flags_t;

  // Data field of a codeword; check bits sit above it.
  function automatic logic [DATA_W-1:0] cw_data(input logic [CW_W-1:0] cw);
    return cw[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : zero the count (an inc in the same cycle still counts)
//   inc        : add one unless already at all-ones
//   cnt        : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear takes priority, then the increment lands on top of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= inc ? CNT_ONE : '0;
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/ecc_dec_resp.sv
// ecc_dec_resp: registered response stage behind the SEC-DED decoder.
//   in_*    : decoder result (codeword, syndrome, flags, address), valid/ready
//   out_*   : corrected read data and poison flag, valid/ready
//   scrub_* : single-entry write-back request of corrected codewords, overflow flag
//   sec_cnt / ded_cnt : saturating single/double error counts
//   log_*   : first-error syndrome/address/type, cleared by log_clr
//   irq     : level interrupt mirroring log_valid
module ecc_dec_resp
  import ecc_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  input  logic [CHK_W-1:0]  in_syn,
  input  logic              in_err,
  input  logic              in_sgl,
  input  logic              in_dbl,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_poison,
  output logic              scrub_req,
  input  logic              scrub_ack,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic [CW_W-1:0]   scrub_cw,
  output logic              scrub_ovf,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt,
  output logic              log_valid,
  output logic [CHK_W-1:0]  log_syn,
  output logic [ADDR_W-1:0] log_addr,
  output logic              log_dbl,
  input  logic              log_clr,
  output logic              irq
);

  ecc_flags_t        flags_s;
  logic              acc_s;
  logic              rdy_en_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_poison_r;
  logic              log_valid_r;
  logic [CHK_W-1:0]  log_syn_r;
  logic [ADDR_W-1:0] log_addr_r;
  logic              log_dbl_r;
  scrub_state_t      state_r;
  scrub_state_t      state_nxt_s;
  logic              load_s;
  logic              drop_s;
  logic              scrub_req_s;
  logic [ADDR_W-1:0] scrub_addr_r;
  logic [CW_W-1:0]   scrub_cw_r;
  logic              scrub_ovf_r;

  assign flags_s = '{err: in_err, sgl: in_sgl, dbl: in_dbl};

  // rdy_en_r keeps in_ready low while reset is held and for that edge only.
  assign in_ready = rdy_en_r & (~out_valid_r | out_ready);
  assign acc_s    = in_valid & in_ready;

  // Ready enable: rises on the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_en_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
    end
  end

  // Output pipeline register: load on accept, drop valid once consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_poison_r <= 1'b0;
    end else if (acc_s) begin
      out_valid_r  <= 1'b1;
      out_data_r   <= cw_data(in_cw);
      out_poison_r <= flags_s.dbl;
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= out_data_r;
      out_poison_r <= out_poison_r;
    end else begin
      out_valid_r  <= out_valid_r;
      out_data_r   <= out_data_r;
      out_poison_r <= out_poison_r;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_sec_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (log_clr),
    .inc   (acc_s & flags_s.sgl),
    .cnt   (sec_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ded_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (log_clr),
    .inc   (acc_s & flags_s.dbl),
    .cnt   (ded_cnt)
  );

  // First-error log: a clear in the same cycle re-arms capture for this error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      log_valid_r <= 1'b0;
      log_syn_r   <= '0;
      log_addr_r  <= '0;
      log_dbl_r   <= 1'b0;
    end else if (acc_s && flags_s.err && (!log_valid_r || log_clr)) begin
      log_valid_r <= 1'b1;
      log_syn_r   <= in_syn;
      log_addr_r  <= in_addr;
      log_dbl_r   <= flags_s.dbl;
    end else if (log_clr) begin
      log_valid_r <= 1'b0;
      log_syn_r   <= '0;
      log_addr_r  <= '0;
      log_dbl_r   <= 1'b0;
    end else begin
      log_valid_r <= log_valid_r;
      log_syn_r   <= log_syn_r;
      log_addr_r  <= log_addr_r;
      log_dbl_r   <= log_dbl_r;
    end
  end

  // Scrub FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Scrub FSM next state: the ack cycle frees the slot for a new entry.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (acc_s && flags_s.sgl) begin
          state_nxt_s = REQ;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (scrub_ack) begin
          if (acc_s && flags_s.sgl) begin
            state_nxt_s = REQ;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = REQ;
          drop_s      = acc_s & flags_s.sgl;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Scrub FSM outputs.
  always_comb begin
    scrub_req_s = 1'b0;
    case (state_r)
      IDLE:    scrub_req_s = 1'b0;
      REQ:     scrub_req_s = 1'b1;
      default: scrub_req_s = 1'b0;
    endcase
  end

  // Scrub entry and sticky overflow; a clear plus a drop leaves the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scrub_addr_r <= '0;
      scrub_cw_r   <= '0;
      scrub_ovf_r  <= 1'b0;
    end else begin
      scrub_addr_r <= load_s ? in_addr : scrub_addr_r;
      scrub_cw_r   <= load_s ? in_cw : scrub_cw_r;
      scrub_ovf_r  <= drop_s | (scrub_ovf_r & ~log_clr);
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_poison = out_poison_r;
  assign scrub_req  = scrub_req_s;
  assign scrub_addr = scrub_addr_r;
  assign scrub_cw   = scrub_cw_r;
  assign scrub_ovf  = scrub_ovf_r;
  assign log_valid  = log_valid_r;
  assign log_syn    = log_syn_r;
  assign log_addr   = log_addr_r;
  assign log_dbl    = log_dbl_r;
  assign irq        = log_valid_r;

endmodule

// File: tb/tb_ecc_dec_resp.sv
// tb_ecc_dec_resp: directed self-checking bench for ecc_dec_resp (CNT_W=4).
module tb_ecc_dec_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [38:0] in_cw;
  logic [6:0]  in_syn;
  logic        in_err;
  logic        in_sgl;
  logic        in_dbl;
  logic [15:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_poison;
  logic        scrub_req;
  logic        scrub_ack;
  logic [15:0] scrub_addr;
  logic [38:0] scrub_cw;
  logic        scrub_ovf;
  logic [3:0]  sec_cnt;
  logic [3:0]  ded_cnt;
  logic        log_valid;
  logic [6:0]  log_syn;
  logic [15:0] log_addr;
  logic        log_dbl;
  logic        log_clr;
  logic        irq;

  int checks = 0;
  int errors = 0;

  ecc_dec_resp #(.ADDR_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw), .in_syn(in_syn),
    .in_err(in_err), .in_sgl(in_sgl), .in_dbl(in_dbl), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_poison(out_poison), .scrub_req(scrub_req), .scrub_ack(scrub_ack),
    .scrub_addr(scrub_addr), .scrub_cw(scrub_cw), .scrub_ovf(scrub_ovf),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .log_valid(log_valid),
    .log_syn(log_syn), .log_addr(log_addr), .log_dbl(log_dbl),
    .log_clr(log_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [38:0] cw, input logic [6:0] syn, input logic err,
                       input logic sgl, input logic dbl, input logic [15:0] addr);
    in_valid = 1'b1;
    in_cw    = cw;
    in_syn   = syn;
    in_err   = err;
    in_sgl   = sgl;
    in_dbl   = dbl;
    in_addr  = addr;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_cw = 39'd0; in_syn = 7'd0; in_err = 1'b0;
    in_sgl = 1'b0; in_dbl = 1'b0; in_addr = 16'd0; out_ready = 1'b1;
    scrub_ack = 1'b0; log_clr = 1'b0;

    // Reset state
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sec", 64'(sec_cnt), 64'd0);
    chk("rst_ded", 64'(ded_cnt), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_scrub_req", 64'(scrub_req), 64'd0);
    chk("rst_ovf", 64'(scrub_ovf), 64'd0);
    rst_n = 1'b1;
    chk("rel_in_ready_low", 64'(in_ready), 64'd0);
    step();
    chk("rel_in_ready_high", 64'(in_ready), 64'd1);

    // Clean read
    offer(39'h00_DEAD_BEEF, 7'd0, 1'b0, 1'b0, 1'b0, 16'h0010);
    step();
    in_valid = 1'b0;
    chk("clean_valid", 64'(out_valid), 64'd1);
    chk("clean_data", 64'(out_data), 64'hDEADBEEF);
    chk("clean_poison", 64'(out_poison), 64'd0);
    chk("clean_sec", 64'(sec_cnt), 64'd0);
    chk("clean_scrub", 64'(scrub_req), 64'd0);
    chk("clean_log", 64'(log_valid), 64'd0);

    // Single-bit error
    offer(39'h5A_1234_5678, 7'b0000111, 1'b1, 1'b1, 1'b0, 16'h0040);
    step();
    in_valid = 1'b0;
    chk("sgl_data", 64'(out_data), 64'h12345678);
    chk("sgl_sec", 64'(sec_cnt), 64'd1);
    chk("sgl_log_syn", 64'(log_syn), 64'h07);
    chk("sgl_log_addr", 64'(log_addr), 64'h0040);
    chk("sgl_irq", 64'(irq), 64'd1);
    chk("sgl_req", 64'(scrub_req), 64'd1);
    chk("sgl_scrub_cw", 64'(scrub_cw), 64'h5A_1234_5678);
    chk("sgl_scrub_addr", 64'(scrub_addr), 64'h0040);
    step(); step();
    chk("sgl_req_hold", 64'(scrub_req), 64'd1);
    chk("sgl_cw_hold", 64'(scrub_cw), 64'h5A_1234_5678);
    scrub_ack = 1'b1;
    step();
    scrub_ack = 1'b0;
    chk("sgl_req_done", 64'(scrub_req), 64'd0);

    // Double-bit error
    offer(39'h01_CAFE_F00D, 7'h2A, 1'b1, 1'b0, 1'b1, 16'h0080);
    step();
    in_valid = 1'b0;
    chk("dbl_poison", 64'(out_poison), 64'd1);
    chk("dbl_ded", 64'(ded_cnt), 64'd1);
    chk("dbl_sec", 64'(sec_cnt), 64'd1);
    chk("dbl_log_addr", 64'(log_addr), 64'h0040);
    chk("dbl_log_dbl", 64'(log_dbl), 64'd0);
    chk("dbl_no_scrub", 64'(scrub_req), 64'd0);
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure
    out_ready = 1'b0;
    offer(39'h00_1111_1111, 7'd0, 1'b0, 1'b0, 1'b0, 16'h0001);
    step();
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    offer(39'h00_2222_2222, 7'd0, 1'b0, 1'b0, 1'b0, 16'h0002);
    step();
    chk("bp_hold1", 64'(out_data), 64'h11111111);
    step();
    chk("bp_hold2", 64'(out_data), 64'h11111111);
    chk("bp_ready_still_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_second", 64'(out_data), 64'h22222222);
    chk("bp_second_valid", 64'(out_valid), 64'd1);

    // Scrub overflow, then a reload in the ack cycle
    log_clr = 1'b1;
    step();
    log_clr = 1'b0;
    chk("clr_sec", 64'(sec_cnt), 64'd0);
    chk("clr_ded", 64'(ded_cnt), 64'd0);
    chk("clr_log", 64'(log_valid), 64'd0);
    offer(39'h33_0000_0C0C, 7'h0B, 1'b1, 1'b1, 1'b0, 16'h0100);
    step();
    offer(39'h44_0000_0D0D, 7'h0C, 1'b1, 1'b1, 1'b0, 16'h0200);
    step();
    in_valid = 1'b0;
    chk("ovf_addr", 64'(scrub_addr), 64'h0100);
    chk("ovf_cw", 64'(scrub_cw), 64'h33_0000_0C0C);
    chk("ovf_flag", 64'(scrub_ovf), 64'd1);
    chk("ovf_sec", 64'(sec_cnt), 64'd2);
    chk("ovf_log_addr", 64'(log_addr), 64'h0100);
    scrub_ack = 1'b1;
    offer(39'h55_0000_0E0E, 7'h0D, 1'b1, 1'b1, 1'b0, 16'h0300);
    step();
    in_valid = 1'b0;
    chk("reload_req", 64'(scrub_req), 64'd1);
    chk("reload_addr", 64'(scrub_addr), 64'h0300);
    chk("reload_cw", 64'(scrub_cw), 64'h55_0000_0E0E);
    chk("reload_sec", 64'(sec_cnt), 64'd3);
    step();
    scrub_ack = 1'b0;
    chk("reload_done", 64'(scrub_req), 64'd0);

    // Saturation, then clear together with a double-bit accept
    log_clr = 1'b1;
    step();
    log_clr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      offer(39'h00_0000_0001, 7'h01, 1'b1, 1'b1, 1'b0, 16'(i));
      step();
    end
    in_valid = 1'b0;
    chk("sat_sec", 64'(sec_cnt), 64'd15);
    log_clr = 1'b1;
    offer(39'h7F_0BAD_0BAD, 7'h55, 1'b1, 1'b0, 1'b1, 16'h0AAA);
    step();
    log_clr = 1'b0;
    in_valid = 1'b0;
    chk("clrdbl_ded", 64'(ded_cnt), 64'd1);
    chk("clrdbl_sec", 64'(sec_cnt), 64'd0);
    chk("clrdbl_log_valid", 64'(log_valid), 64'd1);
    chk("clrdbl_log_dbl", 64'(log_dbl), 64'd1);
    chk("clrdbl_log_addr", 64'(log_addr), 64'h0AAA);
    chk("clrdbl_log_syn", 64'(log_syn), 64'h55);
    chk("clrdbl_ovf", 64'(scrub_ovf), 64'd0);

    // Reset mid-transfer discards output and pending scrub
    out_ready = 1'b0;
    offer(39'h00_0000_ABCD, 7'd0, 1'b0, 1'b0, 1'b0, 16'h0005);
    step();
    in_valid = 1'b0;
    chk("mid_valid", 64'(out_valid), 64'd1);
    chk("mid_req", 64'(scrub_req), 64'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_req", 64'(scrub_req), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_irq", 64'(irq), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
